// File: rtl/nvme_pkg.sv
// Shared definitions for the NVMe host link: word width, FSM states, default timing.
package nvme_pkg;

  localparam int unsigned NVME_WORD_W          = 16;
  localparam int unsigned NVME_TIMEOUT_CYCLES  = 256;
  localparam int unsigned NVME_IRQ_POLL_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_WAIT_IRQ,
    ST_ACK_IRQ
  } link_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nvme_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full is derived from the registered count only.
module nvme_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nvme_host_link.sv
// Host-side NVMe link endpoint: one outstanding command, buffered commands and completions,
// response timeout and interrupt handshake (irq-driven or polled).
module nvme_host_link
  import nvme_pkg::*;
#(
  parameter int unsigned CMD_DEPTH       = 4,
  parameter int unsigned CPL_DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES  = NVME_TIMEOUT_CYCLES,
  parameter int unsigned IRQ_POLL_CYCLES = NVME_IRQ_POLL_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  input  logic [NVME_WORD_W-1:0] cmd_data,
  output logic                   cmd_ready,
  output logic                   cpl_valid,
  output logic [NVME_WORD_W-1:0] cpl_data,
  input  logic                   cpl_ready,
  output logic                   dev_rx_valid,
  output logic [NVME_WORD_W-1:0] dev_rx_data,
  input  logic                   dev_tx_ready,
  input  logic [NVME_WORD_W-1:0] dev_tx_data,
  output logic                   dev_tx_ack,
  input  logic                   dev_irq_req,
  output logic                   dev_irq_ack,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   timeout_clr
);

  localparam int unsigned CNT_MAX = max_u(TIMEOUT_CYCLES, IRQ_POLL_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(IRQ_POLL_CYCLES - 1);

  link_state_e            state;
  link_state_e            state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   tmo_hit;
  logic                   cmd_full;
  logic                   cmd_empty;
  logic                   cpl_full;
  logic                   cpl_empty;
  logic                   cmd_pop;
  logic                   cpl_push;
  logic [NVME_WORD_W-1:0] cmd_head;

  assign cmd_pop    = (state == ST_ISSUE);
  assign cpl_push   = (state == ST_WAIT_RSP) && dev_tx_ready;
  assign dev_tx_ack = cpl_push;
  assign cmd_ready  = !cmd_full;
  assign cpl_valid  = !cpl_empty;
  assign busy       = (state != ST_IDLE) || !cmd_empty;

  nvme_sync_fifo #(.WIDTH(NVME_WORD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid),
    .push_data (cmd_data),
    .pop       (cmd_pop),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .head      (cmd_head)
  );

  nvme_sync_fifo #(.WIDTH(NVME_WORD_W), .DEPTH(CPL_DEPTH)) u_cpl_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cpl_push),
    .push_data (dev_tx_data),
    .pop       (cpl_ready),
    .full      (cpl_full),
    .empty     (cpl_empty),
    .head      (cpl_data)
  );

  // Next state; a response on the timeout cycle wins over the abort.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE:     if (!cmd_empty && !cpl_full) state_nxt = ST_ISSUE;
      ST_ISSUE:    state_nxt = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        if (dev_tx_ready) begin
          state_nxt = ST_WAIT_IRQ;
        end else if (cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_ACK_IRQ;
        end
      end
      ST_WAIT_IRQ: if (dev_irq_req || (cnt == POLL_LAST)) state_nxt = ST_ACK_IRQ;
      ST_ACK_IRQ:  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      dev_rx_valid <= 1'b0;
      dev_rx_data  <= '0;
      dev_irq_ack  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      dev_rx_valid <= (state_nxt == ST_ISSUE);
      dev_rx_data  <= (state_nxt == ST_ISSUE) ? cmd_head : '0;
      dev_irq_ack  <= (state_nxt == ST_ACK_IRQ);
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (timeout_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nvme_host_link.sv
// Scoreboard bench for nvme_host_link with a behavioural device model and randomized traffic.
module tb_nvme_host_link;

  localparam int TMO  = 256;
  localparam int POLL = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready;
  logic        cpl_valid;
  logic [15:0] cpl_data;
  logic        cpl_ready = 1'b1;
  logic        dev_rx_valid;
  logic [15:0] dev_rx_data;
  logic        dev_tx_ready;
  logic [15:0] dev_tx_data;
  logic        dev_tx_ack;
  logic        dev_irq_req;
  logic        dev_irq_ack;
  logic        busy;
  logic        timeout_err;
  logic        timeout_clr = 1'b0;

  nvme_host_link #(
    .CMD_DEPTH(4), .CPL_DEPTH(4), .TIMEOUT_CYCLES(TMO), .IRQ_POLL_CYCLES(POLL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cpl_valid(cpl_valid), .cpl_data(cpl_data), .cpl_ready(cpl_ready),
    .dev_rx_valid(dev_rx_valid), .dev_rx_data(dev_rx_data),
    .dev_tx_ready(dev_tx_ready), .dev_tx_data(dev_tx_data), .dev_tx_ack(dev_tx_ack),
    .dev_irq_req(dev_irq_req), .dev_irq_ack(dev_irq_ack),
    .busy(busy), .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    else n_pass++;
  endfunction

  // Device behaviour: response word per command
  function automatic logic [15:0] resp_of(input logic [15:0] c);
    return (c == 16'h1234) ? 16'hBEEF : (c ^ 16'hC3C3);
  endfunction

  logic [15:0] issue_q[$];
  logic [15:0] cpl_q[$];

  bit dev_respond = 1'b1;
  bit dev_irq_en  = 1'b1;
  int dev_delay   = 2;

  int rx_cnt = 0, tx_cnt = 0, irq_cnt = 0, cpl_cnt = 0;
  int last_rx_cyc = 0, last_tx_cyc = 0, last_irq_cyc = 0, last_cpl_cyc = 0;
  int acc_cyc = 0;
  bit prev_rx = 0, prev_tx = 0, prev_irq = 0;

  // Monitor: scoreboards for device rx words and completions, plus pulse shape checks
  always @(negedge clk) begin
    if (reset_n) begin
      if (dev_rx_valid) begin
        rx_cnt++;
        last_rx_cyc = cyc;
        if (issue_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
        else chk("rx_data", 32'(dev_rx_data), 32'(issue_q.pop_front()));
      end
      if (dev_tx_ack) begin
        tx_cnt++;
        last_tx_cyc = cyc;
      end
      if (dev_irq_ack) begin
        irq_cnt++;
        last_irq_cyc = cyc;
      end
      if (dev_rx_valid || dev_tx_ack || dev_irq_ack) begin
        chk("pulse_onehot", 32'(int'(dev_rx_valid) + int'(dev_tx_ack) + int'(dev_irq_ack)), 32'd1);
        chk("pulse_width", 32'({prev_rx & dev_rx_valid, prev_tx & dev_tx_ack, prev_irq & dev_irq_ack}), 32'd0);
      end
      if (cpl_valid && cpl_ready) begin
        cpl_cnt++;
        last_cpl_cyc = cyc;
        if (cpl_q.size() == 0) chk("cpl_unexpected", 32'(cpl_data), 32'hFFFF_FFFF);
        else chk("cpl_data", 32'(cpl_data), 32'(cpl_q.pop_front()));
      end
    end
    prev_rx  = dev_rx_valid;
    prev_tx  = dev_tx_ack;
    prev_irq = dev_irq_ack;
  end

  // Device model: answers dev_delay cycles after rx, raises irq the cycle after its response
  logic [15:0] dcmd;
  initial begin
    dev_tx_ready = 1'b0;
    dev_tx_data  = '0;
    dev_irq_req  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset_n && dev_rx_valid && dev_respond) begin
        dcmd = dev_rx_data;
        repeat (dev_delay) begin @(posedge clk); #1; end
        dev_tx_ready = 1'b1;
        dev_tx_data  = resp_of(dcmd);
        @(posedge clk); #1;
        dev_tx_ready = 1'b0;
        dev_tx_data  = '0;
        if (dev_irq_en) begin
          dev_irq_req = 1'b1;
          for (int k = 0; k < 64 && !dev_irq_ack; k++) begin @(posedge clk); #1; end
          dev_irq_req = 1'b0;
        end
      end
    end
  end

  // Offer one command; expectations are queued before the accept edge
  task automatic send_cmd(input logic [15:0] d, input bit exp_cpl);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && n < 4000) begin @(posedge clk); #1; n++; end
    if (n >= 4000) begin
      chk("cmd_accept_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    issue_q.push_back(d);
    if (exp_cpl) cpl_q.push_back(resp_of(d));
    @(posedge clk); #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin @(posedge clk); #1; n++; end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int base_rx, base_tx, n_wait, tgt;
  bit push_done, rnd_done;

  initial begin
    tick(3);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outputs", 32'({cpl_valid, dev_rx_valid, dev_tx_ack, dev_irq_ack, busy, timeout_err}), 32'd0);
    chk("rst_rx_data", 32'(dev_rx_data), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Single command with irq-driven completion
    send_cmd(16'h1234, 1'b1);
    wait_idle("single");
    chk("single_rx_lat", 32'(last_rx_cyc - acc_cyc), 32'd1);
    chk("single_tx_lat", 32'(last_tx_cyc - last_rx_cyc), 32'd2);
    chk("single_cpl_lat", 32'(last_cpl_cyc - last_tx_cyc), 32'd1);
    chk("single_irq_lat", 32'(last_irq_cyc - last_tx_cyc), 32'd2);
    tick(1);
    chk("single_busy", 32'(busy), 32'd0);

    // Backpressure: completion FIFO fills, command FIFO fills behind it
    cpl_ready = 1'b0;
    base_rx   = rx_cnt;
    push_done = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send_cmd(16'(i), 1'b1);
        push_done = 1'b1;
      end
    join_none
    tick(150);
    chk("bp_issued", 32'(rx_cnt - base_rx), 32'd4);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_cpl_valid", 32'(cpl_valid), 32'd1);
    cpl_ready = 1'b1;
    n_wait = 0;
    while (!(push_done && !busy && !cpl_valid) && n_wait < 2000) begin tick(1); n_wait++; end
    chk("bp_drained", 32'(cpl_valid), 32'd0);
    chk("bp_issued_all", 32'(rx_cnt - base_rx), 32'd8);
    chk("bp_sb_empty", 32'(cpl_q.size()), 32'd0);

    // Response timeout
    dev_respond = 1'b0;
    base_tx = tx_cnt;
    send_cmd(16'h0A0A, 1'b0);
    wait_idle("tmo");
    chk("tmo_irq_lat", 32'(last_irq_cyc - last_rx_cyc), 32'(TMO + 1));
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_cpl_valid", 32'(cpl_valid), 32'd0);
    chk("tmo_no_ack", 32'(tx_cnt - base_tx), 32'd0);
    dev_respond = 1'b1;
    send_cmd(16'h0B0B, 1'b1);
    wait_idle("tmo_next");
    tick(1);
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
    timeout_clr = 1'b1;
    tick(1);
    timeout_clr = 1'b0;
    chk("tmo_err_cleared", 32'(timeout_err), 32'd0);

    // Polled interrupt
    dev_irq_en = 1'b0;
    send_cmd(16'h5555, 1'b1);
    wait_idle("poll");
    chk("poll_irq_lat", 32'(last_irq_cyc - last_tx_cyc), 32'(POLL + 1));
    chk("poll_err", 32'(timeout_err), 32'd0);
    dev_irq_en = 1'b1;

    // Response on the timeout cycle counts as a response
    dev_delay = TMO;
    send_cmd(16'h7E57, 1'b1);
    wait_idle("late");
    chk("late_tx_lat", 32'(last_tx_cyc - last_rx_cyc), 32'(TMO));
    chk("late_err", 32'(timeout_err), 32'd0);
    dev_delay = 2;

    // Clear on the timeout cycle loses to the set
    dev_respond = 1'b0;
    send_cmd(16'hC011, 1'b0);
    tgt = acc_cyc + 1 + TMO;
    while (cyc < tgt) tick(1);
    timeout_clr = 1'b1;
    tick(1);
    timeout_clr = 1'b0;
    chk("coll_irq_ack", 32'(dev_irq_ack), 32'd1);
    chk("coll_err", 32'(timeout_err), 32'd1);
    wait_idle("coll");

    // Reset in WAIT_RSP
    send_cmd(16'hDEAD, 1'b0);
    tick(5);
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("rst_mid_pulses", 32'({dev_rx_valid, dev_tx_ack, dev_irq_ack}), 32'd0);
    chk("rst_mid_state", 32'({cpl_valid, cmd_ready, busy, timeout_err}), 32'b0100);
    dev_respond = 1'b1;
    tick(2);

    // Randomized traffic with random completion backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          dev_delay  = int'($urandom_range(1, 6));
          dev_irq_en = 1'($urandom_range(0, 1));
          send_cmd(16'($urandom), 1'b1);
          wait_idle("rnd");
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick(1);
          cpl_ready = ($urandom_range(0, 3) != 0);
        end
        cpl_ready = 1'b1;
      end
    join
    n_wait = 0;
    while (cpl_valid && n_wait < 200) begin tick(1); n_wait++; end
    chk("rnd_cpl_drained", 32'(cpl_valid), 32'd0);
    chk("rnd_sb_cpl", 32'(cpl_q.size()), 32'd0);
    chk("rnd_sb_issue", 32'(issue_q.size()), 32'd0);
    chk("rnd_err", 32'(timeout_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    n_chk++;
    $display("FAIL watchdog: actual=running required=finished");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
